// File: rtl/usb_pkg.sv
// Shared ULPI definitions: byte width, RX FIFO entry layout and write-side states.
package usb_pkg;

  localparam int ULPI_DATA_W  = 8;
  localparam int FIFO_ENTRY_W = ULPI_DATA_W + 2;

  // Entry layout: {err, last, data[7:0]}
  localparam int ENT_DATA = 0;
  localparam int ENT_LAST = ULPI_DATA_W;
  localparam int ENT_ERR  = ULPI_DATA_W + 1;

  typedef enum logic {
    WR_ACCEPT  = 1'b0,
    WR_DISCARD = 1'b1
  } wr_state_t;

endpackage

// File: rtl/ulpi_rx_fifo_ram.sv
// Simple dual-port RAM for the RX packet FIFO: synchronous write, registered read, no reset.
module ulpi_rx_fifo_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ulpi_rx_pkt_fifo.sv
// Store-and-forward ULPI RX packet FIFO: speculative writes are committed on tlast or rolled
// back on overflow/error; committed bytes leave through a first-word-fall-through register.
module ulpi_rx_pkt_fifo
  import usb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter bit DROP_ERRORS = 1'b1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   ulpi_clk,
  input  logic                   ulpi_rst,
  input  logic [ULPI_DATA_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_error,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [ULPI_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_error,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic                   drop_pulse,
  output logic [ADDR_WIDTH:0]    level
);

  logic [ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr, cons_ptr;
  logic [ADDR_WIDTH:0] depth_c, commit_nxt, cons_nxt;
  wr_state_t           state;

  logic beat, full, wr_en, commit_en, drop_now, enter_discard;
  logic rd_vld, out_ld, fetch, out_take;
  logic [FIFO_ENTRY_W-1:0] wr_data, rd_data;

  assign depth_c = {1'b1, {ADDR_WIDTH{1'b0}}};
  assign beat    = s_axis_tvalid & s_axis_tready;
  // Full is judged against the fetch pointer as it stands before this edge.
  assign full    = (wr_ptr - rd_ptr) == depth_c;

  always_comb begin
    wr_en         = 1'b0;
    commit_en     = 1'b0;
    drop_now      = 1'b0;
    enter_discard = 1'b0;
    if (beat) begin
      if (state == WR_DISCARD) begin
        drop_now = s_axis_tlast;
      end else if (full) begin
        drop_now      = s_axis_tlast;
        enter_discard = ~s_axis_tlast;
      end else begin
        wr_en = 1'b1;
        if (s_axis_tlast) begin
          if (s_axis_error && DROP_ERRORS) drop_now  = 1'b1;
          else                             commit_en = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_data                           = '0;
    wr_data[ENT_DATA +: ULPI_DATA_W]  = s_axis_tdata;
    wr_data[ENT_LAST]                 = s_axis_tlast;
    wr_data[ENT_ERR]                  = s_axis_error & s_axis_tlast;
  end

  always_ff @(posedge ulpi_clk or posedge ulpi_rst) begin
    if (ulpi_rst) begin
      state         <= WR_ACCEPT;
      s_axis_tready <= 1'b0;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      drop_pulse    <= 1'b0;
      drop_count    <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      drop_pulse    <= drop_now;
      if (enter_discard)  state <= WR_DISCARD;
      else if (drop_now)  state <= WR_ACCEPT;
      if (drop_now)       wr_ptr <= commit_ptr;
      else if (wr_en)     wr_ptr <= wr_ptr + 1'b1;
      if (commit_en)      commit_ptr <= wr_ptr + 1'b1;
      if (drop_now && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  ulpi_rx_fifo_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(FIFO_ENTRY_W)
  ) u_ram (
    .clk     (ulpi_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (fetch),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (rd_data)
  );

  // Two-stage read: RAM output register (rd_vld) feeds the FWFT output register.
  assign out_take = m_axis_tvalid & m_axis_tready;
  assign out_ld   = rd_vld & (~m_axis_tvalid | m_axis_tready);
  assign fetch    = (commit_ptr != rd_ptr) & (~rd_vld | out_ld);

  assign commit_nxt = commit_en ? wr_ptr + 1'b1 : commit_ptr;
  assign cons_nxt   = cons_ptr + {{ADDR_WIDTH{1'b0}}, out_take};

  always_ff @(posedge ulpi_clk or posedge ulpi_rst) begin
    if (ulpi_rst) begin
      rd_ptr        <= '0;
      cons_ptr      <= '0;
      rd_vld        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_error  <= 1'b0;
      level         <= '0;
    end else begin
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      rd_vld   <= fetch | (rd_vld & ~out_ld);
      cons_ptr <= cons_nxt;
      level    <= commit_nxt - cons_nxt;
      if (out_ld) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= rd_data[ENT_DATA +: ULPI_DATA_W];
        m_axis_tlast  <= rd_data[ENT_LAST];
        m_axis_error  <= rd_data[ENT_ERR];
      end else if (out_take) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ulpi_rx_pkt_fifo.md
# ulpi_rx_pkt_fifo

Parametrised store-and-forward receive packet FIFO between the ULPI link controller's AXI-Stream RX output and the packet decoder. It accepts every beat from the link, so consumer backpressure never forces a mid-packet RX abort. Only complete packets reach the consumer. Packets that overflow, and optionally packets that end with an error, are discarded whole and counted.

## Interface
- ADDR_WIDTH, 9: FIFO depth is 2^ADDR_WIDTH bytes (512 by default).
- DROP_ERRORS, 1: 1 discards packets whose last beat has error set; 0 forwards them with error on the last beat.
- CNT_WIDTH, 8: width of the drop counter.

Ports:
- ulpi_clk  in  1  Only clock; all logic is on the rising edge.
- ulpi_rst  in  1  Reset, asynchronous, active-high.
- s_axis_tdata  in  8  RX byte from the link.
- s_axis_tlast  in  1  Last byte of the packet.
- s_axis_error  in  1  Packet error; valid with tlast.
- s_axis_tvalid  in  1  Input beat valid.
- s_axis_tready  out  1  Constant 1 while not in reset.
- m_axis_tdata  out  8  Output byte.
- m_axis_tlast  out  1  Last byte of the output packet.
- m_axis_error  out  1  Error flag on the last beat; only nonzero when DROP_ERRORS=0.
- m_axis_tvalid  out  1  Output beat valid.
- m_axis_tready  in  1  Consumer ready.
- drop_count  out  CNT_WIDTH  Dropped-packet count; saturates at all-ones.
- drop_pulse  out  1  One-cycle pulse for each dropped packet.
- level  out  ADDR_WIDTH+1  Committed bytes not yet read.

## Operation
- Storage: 10-bit entries {error, last, data} in a simple dual-port RAM.
- Pointers are ADDR_WIDTH+1 bits wide: wr_ptr (speculative), commit_ptr and rd_ptr.
- Full: wr_ptr − rd_ptr == 2^ADDR_WIDTH.
- Empty to the consumer: commit_ptr == rd_ptr.
- Write states:
  - ACCEPT: each beat is written at wr_ptr and wr_ptr increments.
  - A beat that arrives while full sets the packet dropped, is not written, and moves to DISCARD.
  - On tlast, if the packet is not dropped and not (error && DROP_ERRORS), commit_ptr <= wr_ptr+1 (this beat included).
  - Otherwise wr_ptr <= commit_ptr (rollback), drop_pulse is asserted and drop_count increments.
- DISCARD: beats are swallowed until tlast. On tlast: rollback, drop_pulse, counter increment, return to ACCEPT.
- A packet longer than 2^ADDR_WIDTH is always dropped. An overflow on the tlast beat itself drops the packet.
- Read side is first-word-fall-through: the output register fills from RAM whenever it is empty, or is being consumed, and commit_ptr != rd_ptr. The RAM read is registered.
- A packet with no bytes cannot occur, since tlast always rides a data beat.

## Timing
- Reset values: s_axis_tready 0, m_axis_tvalid 0, m_axis_tdata/tlast/error 0, drop_count 0, drop_pulse 0, level 0, all pointers 0. State is ACCEPT.
- s_axis_tready goes to 1 on the first edge after reset deasserts.
- Latency: the first byte is valid on m_axis 2 edges after the edge that accepts the committing tlast, when the output is empty.
- At m_axis_tready=1 with the FIFO non-empty, output throughput is 1 byte/cycle.
- drop_pulse is high during the cycle after the tlast edge. drop_count updates on the same edge.
- level tracks commit_ptr − rd_ptr_consumed, updated each edge.
- Simultaneous commit and read in one cycle are both honoured.
- Full is evaluated against rd_ptr before a same-edge read frees space.
- Reset mid-packet discards all contents, committed and partial, and does not count a drop.

## Structure
- Shared package usb_pkg: ULPI_DATA_W=8 and the FIFO entry field offsets (DATA, LAST, ERR).
- Sub-module ulpi_rx_fifo_ram: simple dual-port, 2^ADDR_WIDTH×10, synchronous write, registered read, no reset.
- The write FSM, commit/rollback logic and FWFT output register live in the top level.

## Test plan
- Write an 8-byte packet (A5,01..07, tlast) with m_axis_tready=1. Expect the same 8 bytes out, tlast on byte 8, error 0, and the first beat 2 cycles after input tlast.
- Hold m_axis_tready=0 and write 3 back-to-back packets of 8 bytes. Expect s_axis_tready to stay 1 and level=24. Release: expect 24 bytes in order with 3 tlasts.
- ADDR_WIDTH=4: write a 20-byte packet, then an 8-byte packet. Expect drop_count=1, one drop_pulse, and only the 8-byte packet output.
- DROP_ERRORS=1: send a packet with error set on tlast. Expect no output and drop_count increments. With DROP_ERRORS=0, expect the packet forwarded with m_axis_error=1 on its last beat only.
- Fill to 15 of 16 bytes committed, then send a 4-byte packet while reading 1 byte per cycle. Expect the new packet fully accepted.
- Assert ulpi_rst after 4 bytes of a packet. Expect level=0, m_axis_tvalid=0 and drop_count=0. A following packet then passes intact.
